// File: rtl/regfile_pkg.sv
// Shared types and helpers for the LEGv8 register file with busy scoreboard.
package regfile_pkg;

    localparam int REG_CNT = 32;
    localparam logic [4:0] XZR_IDX = 5'd31;

    typedef logic [4:0] reg_addr_t;

    function automatic logic is_xzr(reg_addr_t a);
        return a == XZR_IDX;
    endfunction

    function automatic logic [5:0] popcount(logic [REG_CNT-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < REG_CNT; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: one pending-producer flag per register plus a live count.
module scoreboard
    import regfile_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               set,
    input  reg_addr_t          set_idx,
    input  logic               clear,
    input  reg_addr_t          clear_idx,
    output logic [REG_CNT-1:0] busy,
    output logic [5:0]         pending_cnt
);

    logic [REG_CNT-1:0] busy_nxt;

    // Set is applied after clear so a new producer wins over a retiring one.
    always_comb begin
        busy_nxt = busy;
        if (clear) begin
            busy_nxt[clear_idx] = 1'b0;
        end
        if (set) begin
            busy_nxt[set_idx] = 1'b1;
        end
        busy_nxt[XZR_IDX] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            busy        <= busy_nxt;
            pending_cnt <= popcount(busy_nxt);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// LEGv8 32 x N register file with XZR, optional write bypass and busy scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int N      = 64,
    parameter bit BYPASS = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [4:0]   ra1,
    input  logic [4:0]   ra2,
    output logic [N-1:0] rd1,
    output logic [N-1:0] rd2,
    input  logic         we3,
    input  logic [4:0]   wa3,
    input  logic [N-1:0] wd3,
    input  logic         issue_en,
    input  logic [4:0]   issue_rd,
    output logic         busy1,
    output logic         busy2,
    output logic [5:0]   pending_cnt
);

    logic [N-1:0]       regs [REG_CNT];
    logic [REG_CNT-1:0] busy;
    logic               clear;
    logic               set;
    logic               fwd1;
    logic               fwd2;

    assign clear = we3 && !is_xzr(wa3);
    assign set   = issue_en && !is_xzr(issue_rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else if (clear) begin
            regs[wa3] <= wd3;
        end
    end

    assign fwd1 = BYPASS && clear && (wa3 == ra1);
    assign fwd2 = BYPASS && clear && (wa3 == ra2);

    always_comb begin
        rd1 = regs[ra1];
        if (is_xzr(ra1)) begin
            rd1 = '0;
        end else if (fwd1) begin
            rd1 = wd3;
        end
    end

    always_comb begin
        rd2 = regs[ra2];
        if (is_xzr(ra2)) begin
            rd2 = '0;
        end else if (fwd2) begin
            rd2 = wd3;
        end
    end

    // A same-cycle writeback retires the producer when bypass is on.
    assign busy1 = busy[ra1] && !fwd1;
    assign busy2 = busy[ra2] && !fwd2;

    scoreboard u_sb (
        .clk         (clk),
        .reset       (reset),
        .set         (set),
        .set_idx     (issue_rd),
        .clear       (clear),
        .clear_idx   (wa3),
        .busy        (busy),
        .pending_cnt (pending_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: one bypassing and one non-bypassing regfile_sb driven in lockstep.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ra1, ra2, wa3, issue_rd;
    logic        we3, issue_en;
    logic [63:0] wd3;
    logic [63:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        busy1_b, busy2_b, busy1_n, busy2_n;
    logic [5:0]  cnt_b, cnt_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_sb #(.N(64), .BYPASS(1'b1)) u_byp (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2),
        .rd1(rd1_b), .rd2(rd2_b), .we3(we3), .wa3(wa3), .wd3(wd3),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .busy1(busy1_b), .busy2(busy2_b), .pending_cnt(cnt_b)
    );

    regfile_sb #(.N(64), .BYPASS(1'b0)) u_nob (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2),
        .rd1(rd1_n), .rd2(rd2_n), .we3(we3), .wa3(wa3), .wd3(wd3),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .busy1(busy1_n), .busy2(busy2_n), .pending_cnt(cnt_n)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        ie;
        logic [4:0]  ir;
        logic [4:0]  ra;
        logic [63:0] rdb;
        logic        bzb;
        logic [63:0] rdn;
        logic        bzn;
        logic [5:0]  cnt;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        we3 = 1'b0; wa3 = '0; wd3 = '0;
        issue_en = 1'b0; issue_rd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic we, logic [4:0] wa, logic [63:0] wd,
                                logic ie, logic [4:0] ir, logic [4:0] ra,
                                logic [63:0] rdb, logic bzb,
                                logic [63:0] rdn, logic bzn, logic [5:0] cnt);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ir = ir; v.ra = ra;
        v.rdb = rdb; v.bzb = bzb; v.rdn = rdn; v.bzn = bzn; v.cnt = cnt;
        return v;
    endfunction

    localparam logic [63:0] DB = 64'hDEADBEEF_01234567;

    initial begin
        tbl[0]  = mk(1, 5,  DB,        0, 0,  5,  DB,    0, 0,     0, 0);
        tbl[1]  = mk(0, 0,  0,         0, 0,  5,  DB,    0, DB,    0, 0);
        tbl[2]  = mk(1, 31, 64'hFFFF,  0, 0,  31, 0,     0, 0,     0, 0);
        tbl[3]  = mk(0, 0,  0,         0, 0,  31, 0,     0, 0,     0, 0);
        tbl[4]  = mk(0, 0,  0,         1, 7,  7,  0,     0, 0,     0, 0);
        tbl[5]  = mk(1, 7,  64'h77,    0, 0,  7,  64'h77, 0, 0,    1, 1);
        tbl[6]  = mk(0, 0,  0,         0, 0,  7,  64'h77, 0, 64'h77, 0, 0);
        tbl[7]  = mk(1, 9,  64'h99,    1, 9,  9,  64'h99, 0, 0,    0, 0);
        tbl[8]  = mk(0, 0,  0,         0, 0,  9,  64'h99, 1, 64'h99, 1, 1);
        tbl[9]  = mk(0, 0,  0,         1, 4,  4,  0,     0, 0,     0, 1);
        tbl[10] = mk(1, 4,  64'h44,    1, 3,  4,  64'h44, 0, 0,    1, 2);
        tbl[11] = mk(0, 0,  0,         0, 0,  3,  0,     1, 0,     1, 2);
        tbl[12] = mk(1, 10, 64'hA,     0, 0,  10, 64'hA, 0, 0,     0, 2);
        tbl[13] = mk(0, 0,  0,         0, 0,  10, 64'hA, 0, 64'hA, 0, 2);
        tbl[14] = mk(0, 0,  0,         1, 3,  3,  0,     1, 0,     1, 2);
        tbl[15] = mk(0, 0,  0,         1, 31, 4,  64'h44, 0, 64'h44, 0, 2);
        tbl[16] = mk(0, 0,  0,         0, 0,  31, 0,     0, 0,     0, 2);

        reset = 1'b1;
        idle();
        ra1 = '0; ra2 = '0;
        tick();
        tick();
        reset = 1'b0;

        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a);
            ra2 = 5'(31 - a);
            #1;
            chk("rst_rd1", rd1_b | rd1_n, 0);
            chk("rst_rd2", rd2_b | rd2_n, 0);
            chk("rst_busy", {busy1_b, busy2_b, busy1_n, busy2_n}, 0);
        end
        chk("rst_cnt", {cnt_b, cnt_n}, 0);

        for (int i = 0; i < 17; i++) begin
            we3 = tbl[i].we; wa3 = tbl[i].wa; wd3 = tbl[i].wd;
            issue_en = tbl[i].ie; issue_rd = tbl[i].ir;
            ra1 = tbl[i].ra; ra2 = tbl[i].ra;
            #2;
            chk($sformatf("v%0d_rd1_byp", i), rd1_b, tbl[i].rdb);
            chk($sformatf("v%0d_rd2_byp", i), rd2_b, tbl[i].rdb);
            chk($sformatf("v%0d_busy_byp", i), {busy1_b, busy2_b},
                {tbl[i].bzb, tbl[i].bzb});
            chk($sformatf("v%0d_rd1_nob", i), rd1_n, tbl[i].rdn);
            chk($sformatf("v%0d_rd2_nob", i), rd2_n, tbl[i].rdn);
            chk($sformatf("v%0d_busy_nob", i), {busy1_n, busy2_n},
                {tbl[i].bzn, tbl[i].bzn});
            chk($sformatf("v%0d_cnt_byp", i), cnt_b, tbl[i].cnt);
            chk($sformatf("v%0d_cnt_nob", i), cnt_n, tbl[i].cnt);
            tick();
        end
        idle();

        for (int r = 0; r < 31; r++) begin
            issue_en = 1'b1;
            issue_rd = 5'(r);
            tick();
        end
        idle();
        ra1 = 5'd30; ra2 = 5'd0;
        #1;
        chk("sat_cnt_byp", cnt_b, 31);
        chk("sat_cnt_nob", cnt_n, 31);
        chk("sat_busy", {busy1_b, busy2_b, busy1_n, busy2_n}, 4'hF);
        tick();
        chk("sat_hold", cnt_b, 31);

        reset = 1'b1;
        we3 = 1'b1; wa3 = 5'd2; wd3 = 64'd5;
        issue_en = 1'b1; issue_rd = 5'd6;
        tick();
        reset = 1'b0;
        idle();
        ra1 = 5'd2; ra2 = 5'd5;
        #1;
        chk("mid_rst_cnt", {cnt_b, cnt_n}, 0);
        chk("mid_rst_rd2", rd1_b | rd1_n, 0);
        chk("mid_rst_rd5", rd2_b | rd2_n, 0);
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a);
            #1;
            chk("mid_rst_busy", {busy1_b, busy1_n}, 0);
        end
        tick();
        chk("mid_rst_cnt_hold", {cnt_b, cnt_n}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
